// File: rtl/sram_rd_arbiter.sv
// Round-robin read-port arbiter for the shared I/O SRAM: port 0 is the conv engine row fetch,
// port 1 is host/debug readback. Bursts are bounded so neither side can starve the other.
module sram_rd_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arb_en,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] sram_read_address,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic              arb_busy
);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state_reg;
    logic              last_owner_reg;
    logic [3:0]        burst_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              tag1_valid_reg;
    logic              tag1_port_reg;
    logic [1:0]        rsp_valid_reg;

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr [2];
    logic [1:0]        req_ready;
    logic              owned;
    logic              owner;
    logic              owner_valid;
    logic              other_valid;
    logic              win_valid;
    logic              win_port;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;

    // The owner keeps the port until its burst is spent, but only if the other side is waiting.
    always_comb begin
        owned       = (state_reg != IDLE);
        owner       = (state_reg == OWN1);
        owner_valid = req_valid[owner];
        other_valid = req_valid[~owner];
        win_valid   = 1'b0;
        win_port    = 1'b0;
        if (arb_en) begin
            if (owned && owner_valid && ((burst_cnt_reg < BURST_LAST) || !other_valid)) begin
                win_valid = 1'b1;
                win_port  = owner;
            end else if (&req_valid) begin
                win_valid = 1'b1;
                win_port  = owned ? ~owner : ~last_owner_reg;
            end else if (|req_valid) begin
                win_valid = 1'b1;
                win_port  = req_valid[1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = win_valid && (win_port == 1'(gi));
        end
    endgenerate

    assign req0_ready        = req_ready[0];
    assign req1_ready        = req_ready[1];
    assign rsp0_valid        = rsp_valid_reg[0];
    assign rsp1_valid        = rsp_valid_reg[1];
    assign rsp0_data         = sram_read_data;
    assign rsp1_data         = sram_read_data;
    assign sram_read_address = addr_reg;
    assign arb_busy          = (|req_valid) || tag1_valid_reg || (|rsp_valid_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
            burst_cnt_reg  <= '0;
            addr_reg       <= '0;
            tag1_valid_reg <= 1'b0;
            tag1_port_reg  <= 1'b0;
            rsp_valid_reg  <= '0;
        end else begin
            // Tag stage 1 tracks the address cycle, stage 2 lines up with SRAM data.
            tag1_valid_reg   <= win_valid;
            tag1_port_reg    <= win_port;
            rsp_valid_reg[0] <= tag1_valid_reg && !tag1_port_reg;
            rsp_valid_reg[1] <= tag1_valid_reg && tag1_port_reg;
            if (win_valid) begin
                state_reg      <= win_port ? OWN1 : OWN0;
                last_owner_reg <= win_port;
                addr_reg       <= req_addr[win_port];
                if (owned && (owner == win_port)) begin
                    burst_cnt_reg <= (burst_cnt_reg < BURST_LAST) ? burst_cnt_reg + 4'd1
                                                                   : burst_cnt_reg;
                end else begin
                    burst_cnt_reg <= '0;
                end
            end else begin
                state_reg     <= IDLE;
                burst_cnt_reg <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed bench for sram_rd_arbiter: MAX_BURST=4 instance with response scoreboard,
// plus a MAX_BURST=1 instance on the same stimulus for strict alternation.
module tb_sram_rd_arbiter;
    logic        clk;
    logic        reset;
    logic        arb_en;
    logic        req0_valid;
    logic [11:0] req0_addr;
    logic        req1_valid;
    logic [11:0] req1_addr;

    logic        ready0, ready1, rsp0_v, rsp1_v, busy;
    logic [15:0] rsp0_d, rsp1_d, sram_data;
    logic [11:0] sram_addr;

    logic        b_ready0, b_ready1, b_rsp0_v, b_rsp1_v, b_busy;
    logic [15:0] b_rsp0_d, b_rsp1_d, b_sram_data;
    logic [11:0] b_sram_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rsp0_cnt = 0;
    int rsp1_cnt = 0;

    typedef struct packed {
        logic        port;
        logic [11:0] addr;
        logic [31:0] cyc;
    } txn_t;
    txn_t sb[$];

    sram_rd_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .arb_en(arb_en),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(ready0),
        .rsp0_valid(rsp0_v), .rsp0_data(rsp0_d),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(ready1),
        .rsp1_valid(rsp1_v), .rsp1_data(rsp1_d),
        .sram_read_address(sram_addr), .sram_read_data(sram_data), .arb_busy(busy)
    );

    sram_rd_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .reset(reset), .arb_en(arb_en),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(b_ready0),
        .rsp0_valid(b_rsp0_v), .rsp0_data(b_rsp0_d),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(b_ready1),
        .rsp1_valid(b_rsp1_v), .rsp1_data(b_rsp1_d),
        .sram_read_address(b_sram_addr), .sram_read_data(b_sram_data), .arb_busy(b_busy)
    );

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        logic [15:0] x;
        x = {4'b0, a} * 16'd37;
        return x ^ 16'hC3A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: data appears the cycle after the address is presented.
    always @(posedge clk) begin
        sram_data   <= mem_word(sram_addr);
        b_sram_data <= mem_word(b_sram_addr);
    end

    // Scoreboard: push on accept, pop and compare on response.
    always @(negedge clk) begin
        txn_t t;
        if (reset) begin
            sb.delete();
        end else begin
            if (ready0 || ready1) check("one_ready", {31'b0, ready0 & ready1}, 0);
            if (b_rsp0_v || b_rsp1_v) check("b1_rsp_excl", {31'b0, b_rsp0_v & b_rsp1_v}, 0);
            if (rsp0_v || rsp1_v) begin
                if (rsp0_v) rsp0_cnt++;
                if (rsp1_v) rsp1_cnt++;
                check("rsp_excl", {31'b0, rsp0_v & rsp1_v}, 0);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {30'b0, rsp1_v, rsp0_v}, 0);
                end else begin
                    t = sb.pop_front();
                    check("rsp_port", {31'b0, rsp1_v}, {31'b0, t.port});
                    check("rsp_cycle", cyc, t.cyc + 2);
                    check("rsp_data", {16'b0, t.port ? rsp1_d : rsp0_d}, {16'b0, mem_word(t.addr)});
                    $display("rsp port=%0d addr=%03h data=%04h cyc=%0d",
                             t.port, t.addr, t.port ? rsp1_d : rsp0_d, cyc);
                end
            end
            if (req0_valid && ready0) sb.push_back('{1'b0, req0_addr, 32'(cyc)});
            if (req1_valid && ready1) sb.push_back('{1'b1, req1_addr, 32'(cyc)});
        end
    end

    initial begin
        logic [11:0] a0, a1;
        reset      = 1'b1;
        arb_en     = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;

        // Reset state
        next_cycle();
        next_cycle();
        #1;
        check("rst_addr", sram_addr, 0);
        check("rst_rsp0", rsp0_v, 0);
        check("rst_rsp1", rsp1_v, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", ready0, 0);
        reset = 1'b0;
        next_cycle();

        // Single port streaming
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            req0_addr  = 12'(i);
            #1;
            check("single_ready0", ready0, 1);
            check("single_ready1", ready1, 0);
            if (i > 0) check("single_addr", sram_addr, i - 1);
            next_cycle();
        end
        req0_valid = 1'b0;
        #1;
        check("single_addr_last", sram_addr, 7);
        next_cycle();
        next_cycle();
        next_cycle();
        check("single_rsp0_count", rsp0_cnt, 8);
        check("single_rsp1_count", rsp1_cnt, 0);

        // Contention from reset: bursts of 4 (and strict alternation on the MAX_BURST=1 copy)
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        a0 = 12'h100;
        a1 = 12'h200;
        for (int i = 0; i < 12; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_addr  = a0;
            req1_addr  = a1;
            #1;
            check("burst4_ready0", ready0, ((i / 4) % 2) == 0);
            check("burst4_ready1", ready1, ((i / 4) % 2) == 1);
            check("burst1_ready0", b_ready0, (i % 2) == 0);
            check("burst1_ready1", b_ready1, (i % 2) == 1);
            if (((i / 4) % 2) == 0) a0 = a0 + 12'd1;
            else                    a1 = a1 + 12'd1;
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();

        // Uncontended owner runs past MAX_BURST; a late arrival then wins at once
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            req0_addr  = 12'h300 + 12'(i);
            #1;
            check("yield_ready0", ready0, 1);
            next_cycle();
        end
        req0_addr  = 12'h308;
        req1_valid = 1'b1;
        req1_addr  = 12'h3F0;
        #1;
        check("sat_ready1", ready1, 1);
        check("sat_ready0", ready0, 0);
        next_cycle();
        req1_valid = 1'b0;
        #1;
        check("resume_ready0", ready0, 1);
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();

        // arb_en low after a port-1 accept
        req1_valid = 1'b1;
        req1_addr  = 12'h0A5;
        #1;
        check("en_ready1", ready1, 1);
        next_cycle();
        req1_valid = 1'b0;
        arb_en     = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 12'h033;
        #1;
        check("en_off_ready0", ready0, 0);
        check("en_off_ready1", ready1, 0);
        check("en_off_b1_ready0", b_ready0, 0);
        check("en_off_addr", sram_addr, 12'h0A5);
        next_cycle();
        req0_valid = 1'b0;
        #1;
        check("en_off_rsp1", rsp1_v, 1);
        check("en_off_busy_hi", busy, 1);
        check("en_off_ready0_b", ready0, 0);
        next_cycle();
        #1;
        check("en_off_busy_lo", busy, 0);
        check("en_off_rsp1_lo", rsp1_v, 0);
        arb_en = 1'b1;
        next_cycle();

        // Reset one cycle after an accept
        req0_valid = 1'b1;
        req0_addr  = 12'h055;
        #1;
        check("mid_ready0", ready0, 1);
        next_cycle();
        req0_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check("mid_rst_addr", sram_addr, 0);
        check("mid_rst_rsp0", rsp0_v, 0);
        check("mid_rst_rsp1", rsp1_v, 0);
        check("mid_rst_busy", busy, 0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_rsp0", rsp0_v, 0);
            check("post_rst_rsp1", rsp1_v, 0);
            next_cycle();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 12'h066;
        req1_addr  = 12'h077;
        #1;
        check("post_rst_win0", ready0, 1);
        check("post_rst_win1", ready1, 0);
        check("post_rst_b1_win0", b_ready0, 1);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
